// File: rtl/game_pkg.sv
// Shared definitions for the zombie-lane game sequencer.
// Holds the FSM state encoding, the lane count and the counter widths
// used by game_sequencer and its button edge detector.
package game_pkg;

    localparam int LANES   = 3;
    localparam int SCORE_W = 8;
    localparam int MISS_W  = 2;
    localparam int CNT_W   = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN_WAIT,
        S_RAND,
        S_UP,
        S_OVER
    } state_e;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for the lane buttons.
// Ports:
//   clk, rst  - clock and asynchronous active-low reset
//   btn       - debounced button levels, one bit per lane
//   press     - btn bits that are high now and were low last cycle
module btn_edge
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] btn,
    output logic [LANES-1:0] press
);

    logic [LANES-1:0] prev_q;
    logic [LANES-1:0] prev_d;

    always_comb prev_d = btn;

    // NOTE: state flops use non-blocking assignment so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= '0;
        else      prev_q <= prev_d;
    end

    assign press = btn & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Whack-a-zombie game sequencer.
// Waits SPAWN_TICKS game ticks, requests a random lane, raises a zombie on
// that lane for up to UP_TICKS ticks and scores a hit when the lane's button
// is pressed. MAX_MISS timeouts end the game.
// Ports:
//   clk, rst            - clock and asynchronous active-low reset
//   tick                - one-cycle game-rate strobe
//   btn[2:0]            - debounced lane buttons
//   rand_req/ack/num    - random-lane request handshake
//   ready/gaming/gameover - registered state indications
//   zombie_up[2:0]      - one-hot raised lane, 0 when none is up
//   shift               - one-cycle pulse per hit
//   score, miss_cnt     - hit count (saturating) and miss count
module game_sequencer
    import game_pkg::*;
#(
    parameter int SPAWN_TICKS = 50,
    parameter int UP_TICKS    = 30,
    parameter int MAX_MISS    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [LANES-1:0]   btn,
    output logic               rand_req,
    input  logic               rand_ack,
    input  logic [1:0]         rand_num,
    output logic               ready,
    output logic               gaming,
    output logic               gameover,
    output logic [LANES-1:0]   zombie_up,
    output logic               shift,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  miss_cnt
);

    localparam logic [CNT_W-1:0]  SPAWN_LIM = CNT_W'(SPAWN_TICKS);
    localparam logic [CNT_W-1:0]  UP_LIM    = CNT_W'(UP_TICKS);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MAX_MISS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [LANES-1:0]   zombie_q, zombie_d;
    logic               rand_req_q, rand_req_d;
    logic               shift_q, shift_d;
    logic               ready_q, ready_d;
    logic               gaming_q, gaming_d;
    logic               gameover_q, gameover_d;
    logic               rel_seen_q, rel_seen_d;

    logic [LANES-1:0]   press;
    logic [CNT_W-1:0]   cnt_inc;
    logic [MISS_W-1:0]  miss_inc;
    logic               any_press, hit, timeout, spawn_done;
    logic               rand_take, rand_ok, leave_over;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    assign cnt_inc    = cnt_q + 1'b1;
    assign miss_inc   = miss_q + 1'b1;
    assign any_press  = |press;
    assign hit        = (state_q == S_UP) && |(press & zombie_q);
    assign timeout    = (state_q == S_UP) && tick && (cnt_inc == UP_LIM);
    assign spawn_done = (state_q == S_SPAWN_WAIT) && tick && (cnt_inc == SPAWN_LIM);
    // An ack only counts while the request is actually raised.
    assign rand_take  = (state_q == S_RAND) && rand_req_q && rand_ack;
    assign rand_ok    = rand_take && (rand_num != 2'd3);
    assign leave_over = (state_q == S_OVER) && any_press && rel_seen_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (any_press)  state_d = S_SPAWN_WAIT;
            S_SPAWN_WAIT: if (spawn_done) state_d = S_RAND;
            S_RAND:       if (rand_ok)    state_d = S_UP;
            S_UP: begin
                // A hit wins over a timeout landing on the same cycle.
                if (hit)          state_d = S_SPAWN_WAIT;
                else if (timeout) state_d = (miss_inc == MISS_LIM) ? S_OVER : S_SPAWN_WAIT;
            end
            S_OVER:       if (leave_over) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic, registered below
    always_comb begin
        cnt_d      = cnt_q;
        score_d    = score_q;
        miss_d     = miss_q;
        zombie_d   = zombie_q;
        shift_d    = 1'b0;
        ready_d    = (state_d == S_IDLE);
        gaming_d   = (state_d == S_SPAWN_WAIT) || (state_d == S_RAND) || (state_d == S_UP);
        gameover_d = (state_d == S_OVER);
        // Dropping for the cycle after any taken ack gives the one-cycle
        // gap before a retry when the lane value is discarded.
        rand_req_d = (state_d == S_RAND) && !rand_take;
        // Release must be seen on a cycle already spent in OVER.
        rel_seen_d = (state_q == S_OVER) && (state_d == S_OVER) &&
                     (rel_seen_q || (btn == '0));

        unique case (state_q)
            S_IDLE: begin
                if (any_press) begin
                    cnt_d   = '0;
                    score_d = '0;
                    miss_d  = '0;
                end
            end
            S_SPAWN_WAIT: begin
                if (tick) cnt_d = spawn_done ? '0 : cnt_inc;
            end
            S_RAND: begin
                if (rand_ok) begin
                    zombie_d = LANES'(3'b001 << rand_num);
                    cnt_d    = '0;
                end
            end
            S_UP: begin
                if (hit) begin
                    score_d  = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                    shift_d  = 1'b1;
                    zombie_d = '0;
                    cnt_d    = '0;
                end else if (timeout) begin
                    miss_d   = miss_inc;
                    zombie_d = '0;
                    cnt_d    = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            score_q    <= '0;
            miss_q     <= '0;
            zombie_q   <= '0;
            rand_req_q <= 1'b0;
            shift_q    <= 1'b0;
            ready_q    <= 1'b1;
            gaming_q   <= 1'b0;
            gameover_q <= 1'b0;
            rel_seen_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            miss_q     <= miss_d;
            zombie_q   <= zombie_d;
            rand_req_q <= rand_req_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            gaming_q   <= gaming_d;
            gameover_q <= gameover_d;
            rel_seen_q <= rel_seen_d;
        end
    end

    assign rand_req  = rand_req_q;
    assign ready     = ready_q;
    assign gaming    = gaming_q;
    assign gameover  = gameover_q;
    assign zombie_up = zombie_q;
    assign shift     = shift_q;
    assign score     = score_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters.
// Expected output vectors are pushed to a scoreboard queue as stimulus is
// driven and popped/compared once the DUT has had the cycle to respond.
// Vector layout: {ready, gaming, gameover, rand_req, zombie_up[2:0],
//                 shift, score[7:0], miss_cnt[1:0]}.
`timescale 1ns/1ps
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [2:0] btn;
    logic       rand_req;
    logic       rand_ack;
    logic [1:0] rand_num;
    logic       ready, gaming, gameover, shift;
    logic [2:0] zombie_up;
    logic [7:0] score;
    logic [1:0] miss_cnt;
    logic [17:0] obs;

    typedef struct {
        string       tag;
        logic [17:0] v;
    } sb_t;

    sb_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    game_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn       (btn),
        .rand_req  (rand_req),
        .rand_ack  (rand_ack),
        .rand_num  (rand_num),
        .ready     (ready),
        .gaming    (gaming),
        .gameover  (gameover),
        .zombie_up (zombie_up),
        .shift     (shift),
        .score     (score),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {ready, gaming, gameover, rand_req, zombie_up, shift, score, miss_cnt};

    function automatic logic [17:0] mk(logic r, logic g, logic o, logic q,
                                       logic [2:0] z, logic s, logic [7:0] sc,
                                       logic [1:0] m);
        return {r, g, o, q, z, s, sc, m};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string tag, logic [17:0] v);
        sb_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        sb_t e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed=%05h expected=%05h", e.tag, obs, e.v);
        end
    endtask

    // Compare now, without advancing the clock.
    task automatic chk_now(string tag, logic [17:0] v);
        push(tag, v);
        pop_cmp();
    endtask

    // Expectation for the state after the next active edge.
    task automatic step_chk(string tag, logic [17:0] v);
        push(tag, v);
        cyc();
        pop_cmp();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    // Run a full spawn wait and raise a zombie on 'lane'.
    task automatic raise(int lane, logic [7:0] sc, logic [1:0] ms);
        ticks(49);
        tick = 1'b1;
        step_chk("spawn_req", mk(0, 1, 0, 1, 3'b000, 0, sc, ms));
        tick = 1'b0;
        cyc();
        rand_ack = 1'b1;
        rand_num = 2'(lane);
        step_chk("raise", mk(0, 1, 0, 0, 3'(1 << lane), 0, sc, ms));
        rand_ack = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; btn = 3'b000; rand_ack = 1'b0; rand_num = 2'd0;
        #2 rst = 1'b0;
        #1 chk_now("reset_async", mk(1, 0, 0, 0, 3'b000, 0, 8'd0, 2'd0));
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk_now("reset_idle", mk(1, 0, 0, 0, 3'b000, 0, 8'd0, 2'd0));

        // Start, spawn 50 ticks, raise lane 2
        btn = 3'b001;
        step_chk("start", mk(0, 1, 0, 0, 3'b000, 0, 8'd0, 2'd0));
        btn = 3'b000;
        cyc();
        ticks(49);
        chk_now("tick49_wait", mk(0, 1, 0, 0, 3'b000, 0, 8'd0, 2'd0));
        tick = 1'b1;
        step_chk("tick50_req", mk(0, 1, 0, 1, 3'b000, 0, 8'd0, 2'd0));
        tick = 1'b0;
        step_chk("req_held", mk(0, 1, 0, 1, 3'b000, 0, 8'd0, 2'd0));
        rand_ack = 1'b1; rand_num = 2'd2;
        step_chk("raise_lane2", mk(0, 1, 0, 0, 3'b100, 0, 8'd0, 2'd0));
        rand_ack = 1'b0;

        // Hit lane 2
        btn = 3'b100;
        step_chk("hit_lane2", mk(0, 1, 0, 0, 3'b000, 1, 8'd1, 2'd0));
        btn = 3'b000;
        step_chk("shift_drop", mk(0, 1, 0, 0, 3'b000, 0, 8'd1, 2'd0));

        // Discarded value 3, retry, then lane 1
        ticks(49);
        tick = 1'b1;
        step_chk("retry_first_req", mk(0, 1, 0, 1, 3'b000, 0, 8'd1, 2'd0));
        tick = 1'b0;
        cyc();
        rand_ack = 1'b1; rand_num = 2'd3;
        step_chk("retry_drop", mk(0, 1, 0, 0, 3'b000, 0, 8'd1, 2'd0));
        rand_ack = 1'b0;
        step_chk("retry_reassert", mk(0, 1, 0, 1, 3'b000, 0, 8'd1, 2'd0));
        rand_ack = 1'b1; rand_num = 2'd1;
        step_chk("raise_lane1", mk(0, 1, 0, 0, 3'b010, 0, 8'd1, 2'd0));
        rand_ack = 1'b0;

        // Wrong lane ignored, then simultaneous multi-bit press with a match
        btn = 3'b001;
        step_chk("wrong_lane", mk(0, 1, 0, 0, 3'b010, 0, 8'd1, 2'd0));
        btn = 3'b000;
        cyc();
        btn = 3'b011;
        step_chk("multi_hit", mk(0, 1, 0, 0, 3'b000, 1, 8'd2, 2'd0));
        btn = 3'b000;
        cyc();

        // Hit on the same cycle as the 30th UP tick
        raise(0, 8'd2, 2'd0);
        ticks(29);
        chk_now("up_29", mk(0, 1, 0, 0, 3'b001, 0, 8'd2, 2'd0));
        btn = 3'b001; tick = 1'b1;
        step_chk("hit_and_timeout", mk(0, 1, 0, 0, 3'b000, 1, 8'd3, 2'd0));
        btn = 3'b000; tick = 1'b0;
        cyc();

        // Three misses
        raise(2, 8'd3, 2'd0);
        ticks(29);
        chk_now("miss1_pending", mk(0, 1, 0, 0, 3'b100, 0, 8'd3, 2'd0));
        tick = 1'b1;
        step_chk("miss1", mk(0, 1, 0, 0, 3'b000, 0, 8'd3, 2'd1));
        tick = 1'b0;
        cyc();
        raise(2, 8'd3, 2'd1);
        ticks(30);
        chk_now("miss2", mk(0, 1, 0, 0, 3'b000, 0, 8'd3, 2'd2));
        raise(0, 8'd3, 2'd2);
        btn = 3'b010;
        cyc();
        ticks(30);
        chk_now("miss3_over", mk(0, 0, 1, 0, 3'b000, 0, 8'd3, 2'd3));

        // OVER exits only after a release
        btn = 3'b110;
        step_chk("held_press_stays", mk(0, 0, 1, 0, 3'b000, 0, 8'd3, 2'd3));
        btn = 3'b000;
        step_chk("release", mk(0, 0, 1, 0, 3'b000, 0, 8'd3, 2'd3));
        btn = 3'b001;
        step_chk("leave_over", mk(1, 0, 0, 0, 3'b000, 0, 8'd3, 2'd3));
        btn = 3'b000;
        cyc();
        btn = 3'b100;
        step_chk("restart_clears", mk(0, 1, 0, 0, 3'b000, 0, 8'd0, 2'd0));
        btn = 3'b000;
        cyc();

        // Score up to saturation
        for (int k = 1; k <= 256; k++) begin
            int lane;
            lane = k % 3;
            raise(lane, (k > 255) ? 8'd255 : 8'(k - 1), 2'd0);
            btn = 3'(1 << lane);
            step_chk("sat_hit", mk(0, 1, 0, 0, 3'b000, 1, (k > 255) ? 8'd255 : 8'(k), 2'd0));
            btn = 3'b000;
            cyc();
        end

        // Asynchronous reset mid-UP
        raise(1, 8'd255, 2'd0);
        #3 rst = 1'b0;
        #1 chk_now("reset_mid_up", mk(1, 0, 0, 0, 3'b000, 0, 8'd0, 2'd0));
        btn = 3'b001;
        cyc();
        chk_now("reset_held_btn", mk(1, 0, 0, 0, 3'b000, 0, 8'd0, 2'd0));
        rst = 1'b1;
        step_chk("start_after_reset", mk(0, 1, 0, 0, 3'b000, 0, 8'd0, 2'd0));
        btn = 3'b000;
        cyc();

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
